ssd_scan_ctrl: RTL and testbench
================================

Name: ssd_scan_ctrl

Overview:
- Time-multiplexes DIGITS hex nibbles onto one shared seven-segment decoder instance. The decoder takes a 4-bit nibble and returns 7 active-low segment lines.
- Sequences the shared decoder slot by slot, drives active-low segment and anode-select lines to the board, and applies per-digit blanking and blinking.
- New display contents are double-buffered and committed atomically at frame boundaries, so no torn frames reach the display.
- Sits between the datapath/register file producing display values and the shared decoder plus display pins.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- PRESCALE, 50000, clk cycles per digit slot (>=2).
- BLINK_FRAMES, 64, full scan frames per blink half-period (>=1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  one-cycle strobe: capture value/digit_en/blink_en into shadow.
- value  in  4*DIGITS  nibble i at [4i+3:4i]; digit 0 is rightmost.
- digit_en  in  DIGITS  1 = digit shown, 0 = digit blanked.
- blink_en  in  DIGITS  1 = digit blinks.
- dec_in  out  4  nibble presented to the shared decoder.
- dec_out  in  7  active-low segments returned by the shared decoder (combinational).
- seg_n  out  7  registered active-low segments to pins.
- an_n  out  DIGITS  registered active-low anode selects.
- update_pending  out  1  shadow holds an uncommitted load.
- frame_done  out  1  one-cycle pulse after each full scan.

Behaviour:
- Reset (async, immediate):
  - prescale counter 0, slot 0, frame counter 0, blink_phase 0.
  - active and shadow value/digit_en/blink_en all 0.
  - update_pending 0, seg_n 7'h7F, an_n all ones, frame_done 0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - At terminal count, slot advances: slot = (slot+1) mod DIGITS.
- Frame boundary: the edge where slot==DIGITS-1 and prescale==PRESCALE-1.
  - frame_done=1 during the following cycle only.
  - Frame counter increments mod BLINK_FRAMES. On wrap, blink_phase toggles.
- Decoder interface:
  - dec_in = active_value[slot], combinational from registered state.
  - dec_out is sampled in the same cycle.
- Output register, each edge, using pre-edge state:
  - show = active_digit_en[slot] & ~(active_blink_en[slot] & blink_phase).
  - dead = (prescale==0): one-cycle anode dead time at each slot start.
  - seg_n <= show ? dec_out : 7'h7F.
  - an_n <= (show & ~dead) ? ~(1<<slot) : all ones.
  - Outputs therefore lag slot state by exactly 1 cycle.
- Load/commit:
  - load=1 writes the shadow and sets update_pending.
  - A second load before commit overwrites the shadow; the last load wins.
  - At a frame boundary with update_pending=1, shadow is copied to active and update_pending clears.
  - load on the frame-boundary edge itself bypasses: the incoming inputs go straight to active and update_pending stays 0.
- Blink phase and commit are independent: a commit does not reset the blink phase.
- Reset mid-frame discards any pending load and restarts scanning at slot 0.
- No combinational path exists from any input to seg_n or an_n.

Test Plan (DIGITS=4, PRESCALE=4, BLINK_FRAMES=2):
- Reset -> seg_n=7'h7F, an_n=4'hF, update_pending=0.
  - First frame_done appears in cycle 16 after reset release.
- load with value=16'h1234, digit_en=4'hF, blink_en=0 at cycle 3.
  - update_pending=1 for cycles 4..15, then 0.
  - From cycle 16, dec_in cycles 4,3,2,1, each held 4 cycles.
  - an_n sequence per slot is F,E,E,E (then F,D,D,D, etc.), lagging dec_in by 1 cycle.
  - seg_n equals dec_out of the prior cycle.
- digit_en=4'b0101 committed -> slots 1 and 3 give seg_n=7'h7F and an_n=4'hF for the full slot.
- blink_en=4'b0001 -> digit 0 is dark in frames 2-3, lit in frames 4-5, and so on.
  - blink_phase toggles every 2 frame_done pulses.
- Two loads (16'hAAAA, then 16'hBBBB) before a boundary -> only 16'hBBBB is ever displayed.
  - load exactly on the boundary edge -> new value active next cycle, update_pending stays 0.
- reset asserted in slot 2 with update_pending=1 -> all outputs return to reset values asynchronously.
  - The pending value is never displayed.

Source files
------------

// File: rtl/ssd_scan_ctrl_if.sv
// Bundle between the display-value producer, the shared seven-segment decoder and the board pins.
// The slave modport is the scan controller's view.
interface ssd_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     digit_en;
    logic [DIGITS-1:0]     blink_en;
    logic [3:0]            dec_in;
    logic [6:0]            dec_out;
    logic [6:0]            seg_n;
    logic [DIGITS-1:0]     an_n;
    logic                  update_pending;
    logic                  frame_done;

    modport slave (
        input  load, value, digit_en, blink_en, dec_out,
        output dec_in, seg_n, an_n, update_pending, frame_done
    );

    modport master (
        output load, value, digit_en, blink_en, dec_out,
        input  dec_in, seg_n, an_n, update_pending, frame_done
    );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scan controller that shares one external decoder across all digits.
// Display contents are double-buffered and swapped in only at frame boundaries.
module ssd_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                reset,
    ssd_scan_ctrl_if.slave      bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = $clog2(DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]         r_prescale;
    logic [SW-1:0]         r_slot;
    logic [FW-1:0]         r_frame;
    logic                  r_blink_phase;
    logic [4*DIGITS-1:0]   r_act_value, r_shd_value;
    logic [DIGITS-1:0]     r_act_en, r_shd_en;
    logic [DIGITS-1:0]     r_act_blink, r_shd_blink;
    logic                  r_pending;
    logic [6:0]            r_seg_n;
    logic [DIGITS-1:0]     r_an_n;
    logic                  r_frame_done;

    logic                  w_tc;
    logic                  w_boundary;
    logic                  w_show;
    logic                  w_dead;
    logic [3:0]            w_dec_in;
    logic [DIGITS-1:0]     w_an_sel;

    assign w_tc       = (r_prescale == PW'(PRESCALE - 1));
    assign w_boundary = w_tc && (r_slot == SW'(DIGITS - 1));
    assign w_dead     = (r_prescale == '0);
    assign w_show     = r_act_en[r_slot] & ~(r_act_blink[r_slot] & r_blink_phase);

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        w_dec_in = '0;
        w_an_sel = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_slot == SW'(i)) begin
                w_dec_in    = r_act_value[4*i +: 4];
                w_an_sel[i] = 1'b0;
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every term reads pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescale    <= '0;
            r_slot        <= '0;
            r_frame       <= '0;
            r_blink_phase <= 1'b0;
            r_act_value   <= '0;
            r_shd_value   <= '0;
            r_act_en      <= '0;
            r_shd_en      <= '0;
            r_act_blink   <= '0;
            r_shd_blink   <= '0;
            r_pending     <= 1'b0;
            r_seg_n       <= 7'h7F;
            r_an_n        <= '1;
            r_frame_done  <= 1'b0;
        end else begin
            r_prescale   <= w_tc ? '0 : r_prescale + PW'(1);
            r_frame_done <= w_boundary;

            if (w_tc) begin
                r_slot <= (r_slot == SW'(DIGITS - 1)) ? '0 : r_slot + SW'(1);
            end

            if (w_boundary) begin
                if (r_frame == FW'(BLINK_FRAMES - 1)) begin
                    r_frame       <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame <= r_frame + FW'(1);
                end
            end

            // A load landing on the boundary edge bypasses the shadow entirely.
            if (bus.load) begin
                r_shd_value <= bus.value;
                r_shd_en    <= bus.digit_en;
                r_shd_blink <= bus.blink_en;
            end
            if (w_boundary && bus.load) begin
                r_act_value <= bus.value;
                r_act_en    <= bus.digit_en;
                r_act_blink <= bus.blink_en;
                r_pending   <= 1'b0;
            end else if (w_boundary && r_pending) begin
                r_act_value <= r_shd_value;
                r_act_en    <= r_shd_en;
                r_act_blink <= r_shd_blink;
                r_pending   <= 1'b0;
            end else if (bus.load) begin
                r_pending <= 1'b1;
            end

            r_seg_n <= w_show ? bus.dec_out : 7'h7F;
            r_an_n  <= (w_show && !w_dead) ? w_an_sel : '1;
        end
    end

    assign bus.dec_in         = w_dec_in;
    assign bus.seg_n          = r_seg_n;
    assign bus.an_n           = r_an_n;
    assign bus.update_pending = r_pending;
    assign bus.frame_done     = r_frame_done;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl: stimulus queues cycle-tagged expectations, a negedge monitor retires them.
module tb_ssd_scan_ctrl;
    localparam int DIGITS = 4;

    typedef enum int {SIG_SEG, SIG_AN, SIG_PEND, SIG_FD, SIG_DEC} sig_e;
    typedef struct {
        int          cyc;
        sig_e        sig;
        logic [15:0] exp;
        string       name;
    } exp_t;

    logic  clk   = 1'b0;
    logic  reset = 1'b1;
    int    cyc   = 0;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    t0 = 0;
    int    t1 = 0;
    exp_t  sb[$];

    ssd_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

    ssd_scan_ctrl #(.DIGITS(DIGITS), .PRESCALE(4), .BLINK_FRAMES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference active-low decoder (segments gfedcba).
    function automatic logic [6:0] s(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    assign bus.dec_out = s(bus.dec_in);

    function automatic logic [15:0] sample(input sig_e sg);
        case (sg)
            SIG_SEG:  return {9'b0, bus.seg_n};
            SIG_AN:   return {12'b0, bus.an_n};
            SIG_PEND: return {15'b0, bus.update_pending};
            SIG_FD:   return {15'b0, bus.frame_done};
            default:  return {12'b0, bus.dec_in};
        endcase
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int c, input sig_e sg, input logic [15:0] v, input string nm);
        exp_t e;
        e.cyc  = c;
        e.sig  = sg;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Expectation relative to the first reset release.
    task automatic ex(input int k, input sig_e sg, input logic [15:0] v);
        push(t0 + k, sg, v, $sformatf("%s@%0d", sg.name(), k));
    endtask

    task automatic goto(input int c);
        int guard = 0;
        while (cyc != c && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != c) begin
            n_tests++;
            n_fail++;
            $display("FAIL goto: reached cycle %0d, expected %0d", cyc, c);
        end
    endtask

    task automatic drive(input logic [15:0] v, input logic [3:0] en, input logic [3:0] bl);
        bus.value    = v;
        bus.digit_en = en;
        bus.blink_en = bl;
        bus.load     = 1'b1;
    endtask

    // Monitor: retire every expectation tagged with the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check(sb[i].name, sample(sb[i].sig), sb[i].exp);
                sb.delete(i);
            end
        end
    end

    initial begin
        bus.load     = 1'b0;
        bus.value    = '0;
        bus.digit_en = '0;
        bus.blink_en = '0;

        push(1, SIG_SEG, 16'h7F, "rst_seg");
        push(1, SIG_AN, 16'hF, "rst_an");
        push(2, SIG_PEND, 16'h0, "rst_pend");
        push(2, SIG_FD, 16'h0, "rst_fd");
        push(2, SIG_DEC, 16'h0, "rst_dec");

        goto(3);
        reset = 1'b0;
        t0    = cyc;

        // First frame, value 1234 committed at the first boundary.
        ex(0, SIG_SEG, 16'h7F);   ex(0, SIG_AN, 16'hF);    ex(0, SIG_PEND, 16'h0);
        ex(3, SIG_PEND, 16'h0);   ex(4, SIG_PEND, 16'h1);  ex(15, SIG_PEND, 16'h1);
        ex(16, SIG_PEND, 16'h0);  ex(15, SIG_FD, 16'h0);   ex(16, SIG_FD, 16'h1);
        ex(17, SIG_FD, 16'h0);    ex(16, SIG_DEC, 16'h4);  ex(19, SIG_DEC, 16'h4);
        ex(20, SIG_DEC, 16'h3);   ex(24, SIG_DEC, 16'h2);  ex(28, SIG_DEC, 16'h1);
        ex(16, SIG_AN, 16'hF);    ex(16, SIG_SEG, 16'h7F); ex(17, SIG_AN, 16'hF);
        ex(17, SIG_SEG, 16'(s(4))); ex(18, SIG_AN, 16'hE); ex(20, SIG_AN, 16'hE);
        ex(21, SIG_AN, 16'hF);    ex(21, SIG_SEG, 16'(s(3))); ex(22, SIG_AN, 16'hD);
        ex(26, SIG_AN, 16'hB);    ex(30, SIG_AN, 16'h7);   ex(30, SIG_SEG, 16'(s(1)));

        // digit_en=0101, blink digit 0; phase is 1 in frames 2-3 and 6-7.
        ex(21, SIG_PEND, 16'h1);  ex(31, SIG_PEND, 16'h1); ex(32, SIG_PEND, 16'h0);
        ex(32, SIG_FD, 16'h1);    ex(34, SIG_SEG, 16'h7F); ex(34, SIG_AN, 16'hF);
        ex(38, SIG_SEG, 16'h7F);  ex(38, SIG_AN, 16'hF);   ex(41, SIG_AN, 16'hF);
        ex(41, SIG_SEG, 16'(s(2))); ex(42, SIG_AN, 16'hB); ex(42, SIG_SEG, 16'(s(2)));
        ex(46, SIG_SEG, 16'h7F);  ex(46, SIG_AN, 16'hF);   ex(48, SIG_FD, 16'h1);
        ex(49, SIG_FD, 16'h0);    ex(50, SIG_AN, 16'hF);   ex(65, SIG_AN, 16'hF);
        ex(65, SIG_SEG, 16'(s(4))); ex(66, SIG_AN, 16'hE); ex(66, SIG_SEG, 16'(s(4)));
        ex(98, SIG_AN, 16'hF);    ex(98, SIG_SEG, 16'h7F);

        // Two loads before one boundary: the last one wins.
        ex(100, SIG_PEND, 16'h0); ex(101, SIG_PEND, 16'h1); ex(104, SIG_DEC, 16'h2);
        ex(106, SIG_PEND, 16'h1); ex(111, SIG_PEND, 16'h1); ex(112, SIG_PEND, 16'h0);
        ex(112, SIG_DEC, 16'hB);  ex(114, SIG_SEG, 16'(s(4'hB))); ex(114, SIG_AN, 16'hE);
        ex(118, SIG_SEG, 16'(s(4'hB))); ex(118, SIG_AN, 16'hD); ex(120, SIG_DEC, 16'hB);
        ex(124, SIG_DEC, 16'hB);

        // Load on the boundary edge goes straight to the active copy.
        ex(127, SIG_PEND, 16'h0); ex(128, SIG_PEND, 16'h0); ex(128, SIG_DEC, 16'h8);
        ex(128, SIG_FD, 16'h1);   ex(130, SIG_SEG, 16'(s(8))); ex(130, SIG_AN, 16'hE);
        ex(132, SIG_DEC, 16'h7);

        // Pending load that a mid-frame reset must discard.
        ex(131, SIG_PEND, 16'h1); ex(137, SIG_PEND, 16'h1); ex(137, SIG_DEC, 16'h6);

        goto(t0 + 3);   drive(16'h1234, 4'hF, 4'h0);
        goto(t0 + 4);   bus.load = 1'b0;
        goto(t0 + 20);  drive(16'h1234, 4'b0101, 4'b0001);
        goto(t0 + 21);  bus.load = 1'b0;
        goto(t0 + 100); drive(16'hAAAA, 4'hF, 4'h0);
        goto(t0 + 101); bus.load = 1'b0;
        goto(t0 + 105); drive(16'hBBBB, 4'hF, 4'h0);
        goto(t0 + 106); bus.load = 1'b0;
        goto(t0 + 127); drive(16'h5678, 4'hF, 4'h0);
        goto(t0 + 128); bus.load = 1'b0;
        goto(t0 + 130); drive(16'h9999, 4'hF, 4'h0);
        goto(t0 + 131); bus.load = 1'b0;

        // Short reset pulse between clock edges exercises the asynchronous path.
        goto(t0 + 137);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        t1 = t0 + 137;
        push(t1 + 1, SIG_SEG, 16'h7F, "arst_seg");
        push(t1 + 1, SIG_AN, 16'hF, "arst_an");
        push(t1 + 1, SIG_PEND, 16'h0, "arst_pend");
        push(t1 + 1, SIG_DEC, 16'h0, "arst_dec");
        push(t1 + 1, SIG_FD, 16'h0, "arst_fd");
        push(t1 + 15, SIG_FD, 16'h0, "arst_fd15");
        push(t1 + 16, SIG_FD, 16'h1, "arst_fd16");
        push(t1 + 17, SIG_DEC, 16'h0, "arst_dec17");
        push(t1 + 17, SIG_PEND, 16'h0, "arst_pend17");
        push(t1 + 18, SIG_SEG, 16'h7F, "arst_seg18");
        push(t1 + 18, SIG_AN, 16'hF, "arst_an18");

        goto(t1 + 20);
        @(negedge clk);
        foreach (sb[i]) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: never sampled, expected %h", sb[i].name, sb[i].exp);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
